// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (16 s_tick per bit).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   rx           serial line (idle high, LSB first), asynchronous to clk
//   s_tick       one-clk enable pulse at 16x baud
//   dout         last received data word (registered, updates with rx_done_tick)
//   rx_done_tick one-clk pulse when a frame completes
//   frame_err    stop bit was sampled low on the last completed frame
//   parity_err   (only with UART_RX_PARITY_EN) even-parity mismatch on last frame
//
// Parameters:
//   DBIT     data bits per frame (5..9)
//   SB_TICK  stop-bit length in s_tick units (16/24/32 = 1/1.5/2 stop bits)
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit, and the parity_err output.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            frame_err
);

    // Tick counter must reach SB_TICK-1 in STOP; 4 bits covers the 16-tick bits.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            // Start detection does not wait for s_tick so the tick phase is
            // counted from the first clk the line is seen low.
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;  // glitch, not a real start bit
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        par_d   = rx_s_q;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit must XOR to 0.
                        perr_d  = (^b_q) ^ par_q;
`endif
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives whole UART frames on rx with s_tick every 4th clk and
// keeps a queue of the frames it sent; every clk the DUT outputs are compared
// against what the frame queue says they must be.
module tb_uart_rx;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rx = 1'b1;
    logic            s_tick = 1'b0;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_err;
`endif

    uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // s_tick high for one clk out of every four
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt   = (tcnt + 1) % 4;
            s_tick = (tcnt == 0);
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_dout;
    logic       m_fe, m_pe;
    int         total, bad, pulses;
    bit         prev_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the frame queue
    initial begin
        m_dout = '0; m_fe = 1'b0; m_pe = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_dout = '0; m_fe = 1'b0; m_pe = 1'b0; prev_done = 1'b0;
            end else begin
                chk("no_back_to_back", {31'd0, rx_done_tick & prev_done}, 32'd0);
                if (rx_done_tick) begin
                    pulses++;
                    chk("pulse_was_expected", {31'd0, q.size() != 0}, 32'd1);
                    if (q.size() != 0) begin
                        exp_t e;
                        e = q.pop_front();
                        m_dout = e.d; m_fe = e.fe; m_pe = e.pe;
                    end
                end
                chk("dout", {24'd0, dout}, {24'd0, m_dout});
                chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
`ifdef UART_RX_PARITY_EN
                chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
`endif
                prev_done = rx_done_tick;
            end
        end
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!s_tick) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) wait_tick();
    endtask

    // One frame: start, 8 data LSB first, [parity], stop, then idle gap.
    // A bad stop bit is low only for 12 ticks so the receiver's sample at
    // mid-stop sees it low and its follow-on false start sees idle high.
    task automatic send_frame(input logic [7:0] d, input bit good, input bit pflip, input int gap);
        exp_t e;
        e.d = d; e.fe = !good; e.pe = pflip;
        q.push_back(e);
        rx = 1'b0; ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ pflip; ticks(16);
`endif
        if (good) begin
            rx = 1'b1; ticks(16);
        end else begin
            rx = 1'b0; ticks(12);
            rx = 1'b1; ticks(4);
        end
        rx = 1'b1;
        ticks(gap);
    endtask

    initial begin
        int p0;
        total = 0; bad = 0; pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", {24'd0, dout}, 32'd0);
        chk("reset_done", {31'd0, rx_done_tick}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        ticks(8);

        p0 = pulses;
        send_frame(8'hA5, 1'b1, 1'b0, 4);
        chk("a5_dout", {24'd0, dout}, 32'hA5);
        chk("a5_ferr", {31'd0, frame_err}, 32'd0);
        chk("a5_pulses", pulses - p0, 32'd1);

        // false start: low for 4 ticks only
        p0 = pulses;
        rx = 1'b0; ticks(4);
        rx = 1'b1; ticks(20);
        chk("false_start_pulses", pulses - p0, 32'd0);
        chk("false_start_dout", {24'd0, dout}, 32'hA5);

        p0 = pulses;
        send_frame(8'h3C, 1'b0, 1'b0, 8);
        chk("3c_dout", {24'd0, dout}, 32'h3C);
        chk("3c_ferr", {31'd0, frame_err}, 32'd1);
        send_frame(8'h55, 1'b1, 1'b0, 4);
        chk("55_dout", {24'd0, dout}, 32'h55);
        chk("55_ferr", {31'd0, frame_err}, 32'd0);
        chk("bad_stop_pulses", pulses - p0, 32'd2);

        p0 = pulses;
        send_frame(8'h00, 1'b1, 1'b0, 0);
        chk("b2b_00_dout", {24'd0, dout}, 32'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 4);
        chk("b2b_ff_dout", {24'd0, dout}, 32'hFF);
        chk("b2b_pulses", pulses - p0, 32'd2);

        // reset during data bit 4 of 0x81, frame abandoned
        p0 = pulses;
        rx = 1'b0; ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0); ticks(16);
        end
        rx = 1'b0; ticks(8);
        reset = 1'b1; rx = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(32);
        chk("midreset_pulses", pulses - p0, 32'd0);
        chk("midreset_dout", {24'd0, dout}, 32'd0);
        send_frame(8'h42, 1'b1, 1'b0, 4);
        chk("42_dout", {24'd0, dout}, 32'h42);
        chk("42_pulses", pulses - p0, 32'd1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 4);
        chk("par_ok_perr", {31'd0, parity_err}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 4);
        chk("par_bad_perr", {31'd0, parity_err}, 32'd1);
        chk("par_bad_dout", {24'd0, dout}, 32'h07);
`endif

        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            bit good, pflip;
            int gap;
            d     = 8'($urandom_range(0, 255));
            good  = ($urandom_range(0, 3) != 0);
            pflip = 1'($urandom_range(0, 1));
            gap   = good ? int'($urandom_range(0, 6)) : int'($urandom_range(8, 14));
            send_frame(d, good, pflip, gap);
        end

        ticks(40);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame (5..9).
REQ-002 Parameter SB_TICK, default 16, stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial line, idle high, LSB-first frames, asynchronous to clk.
REQ-006 s_tick  input  1  one-clk enable pulse at 16x baud rate, from the baud-rate generator.
REQ-007 dout  output  DBIT  last received data word.
REQ-008 rx_done_tick  output  1  one-clk pulse; frame complete, dout/frame_err valid.
REQ-009 frame_err  output  1  stop bit sampled low on the last completed frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY when enabled, see REQ-024).
REQ-012 Tick counter s SHALL be 4 bits, or wider if SB_TICK > 16; bit counter n SHALL be clog2(DBIT) bits; shift register b SHALL be DBIT bits.
REQ-013 IDLE: rx_s == 0 -> START with s = 0; s_tick is not required to leave IDLE.
REQ-014 START: on s_tick with s == 7 (mid start bit): rx_s == 0 -> DATA, s = 0, n = 0; rx_s == 1 -> IDLE (false start, no output change); other s_tick -> s + 1.
REQ-015 DATA: on s_tick with s == 15: s = 0, b = {rx_s, b[DBIT-1:1]}; n == DBIT-1 -> STOP, else n + 1; other s_tick -> s + 1.
REQ-016 STOP: on s_tick with s == SB_TICK-1: rx_done_tick = 1 for that clk, dout = b, frame_err = ~rx_s, -> IDLE; other s_tick -> s + 1.
REQ-017 Cycles without s_tick SHALL hold s, n, b and state, except the IDLE exit in REQ-013.
REQ-018 dout and frame_err SHALL be registered and change only in the cycle rx_done_tick is asserted; they hold between frames.
REQ-019 rx_done_tick SHALL never be high on two consecutive clks.
REQ-020 A frame with a low stop bit SHALL still deliver dout; line low after STOP re-enters START immediately (back-to-back frames).

Reset
REQ-021 reset SHALL force state = IDLE, s = 0, n = 0, b = 0, dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, and both synchronizer flops to 1.
REQ-022 Reset mid-frame SHALL discard the partial word without asserting rx_done_tick; reception restarts at the next falling edge after release.

Configuration
REQ-023 Macro UART_RX_PARITY_EN SHALL control parity support; it is undefined by default.
REQ-024 Defined: add output parity_err (1 bit) and state PARITY between DATA and STOP; on s_tick with s == 15, sample the parity bit (even parity over data bits), s = 0, -> STOP; parity_err updates with rx_done_tick, 1 on mismatch.
REQ-025 Undefined: no PARITY state, no parity_err port; DATA goes directly to STOP.

Verification (DBIT = 8, SB_TICK = 16, s_tick every 4th clk)
REQ-026 Frame 0xA5, valid stop bit -> one rx_done_tick, dout = 0xA5, frame_err = 0.
REQ-027 rx low for 4 s_ticks then high -> no rx_done_tick, dout unchanged, FSM back in IDLE.
REQ-028 Frame 0x3C with stop bit low -> rx_done_tick, dout = 0x3C, frame_err = 1; next good frame 0x55 clears frame_err.
REQ-029 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_done_tick pulses, dout 0x00 then 0xFF.
REQ-030 reset pulsed during bit 4 of 0x81, then frame 0x42 -> no pulse for 0x81; dout = 0x42 after one pulse.
REQ-031 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err = 0; with parity bit 0 -> parity_err = 1, dout = 0x07.
